valid_bank_array: RTL and testbench

Multi-way valid-bit store for the cache tag path. It extends the single-word valid array to WAYS valid bits per set, with these features:
- separate read and write ports;
- per-way write mask;
- a sequenced flash-invalidate engine that walks every set, one per cycle.

It sits beside the tag/data SRAMs and feeds hit detection, so clearing never needs a wide single-cycle reset fan-out.

---
 rtl/valid_bank_array_pkg.sv | 6 +
 rtl/valid_bank_array_clear_seq.sv | 39 +++
 rtl/valid_bank_array.sv | 66 ++++++
 tb/tb_valid_bank_array.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/valid_bank_array_pkg.sv
// CDB_types: shared constants and invalidate-sequencer state type for the valid-bit store.
package CDB_types;
    localparam int S_INDEX_DEF = 4;
    localparam int WAYS_DEF = 4;
    typedef enum logic {IDLE, CLEAR} inv_state_t;
endpackage

// File: rtl/valid_bank_array_clear_seq.sv
// valid_clear_seq: flash-invalidate sequencer that clears one set per cycle.
module valid_clear_seq
    import CDB_types::*;
#(
    parameter int S_INDEX = S_INDEX_DEF
) (
    input  logic               clk0,
    input  logic               rst0,
    input  logic               inv_req,
    output logic               clr_en,
    output logic [S_INDEX-1:0] clr_addr,
    output logic               inv_busy,
    output logic               inv_done
);
    inv_state_t state;
    logic [S_INDEX-1:0] cnt;
    assign clr_en = state == CLEAR;
    assign clr_addr = cnt;
    assign inv_busy = state == CLEAR;
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            state <= IDLE;
            cnt <= '0;
            inv_done <= 1'b0;
        end else begin
            inv_done <= 1'b0;
            if (state == IDLE) begin
                if (inv_req) state <= CLEAR;
            end else begin
                // cnt wraps to 0 on the final set, ready for the next sequence
                cnt <= cnt + 1'b1;
                if (&cnt) begin
                    state <= IDLE;
                    inv_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/valid_bank_array.sv
// valid_bank_array: WAYS valid bits per set with masked writes and sequenced flash invalidate.
// Define VALID_ARRAY_BYPASS_EN to forward a same-cycle write to a read of the same set.
module valid_bank_array
    import CDB_types::*;
#(
    parameter int S_INDEX = S_INDEX_DEF,
    parameter int WAYS = WAYS_DEF
) (
    input  logic               clk0,
    input  logic               rst0,
    input  logic               rd_csb,
    input  logic [S_INDEX-1:0] rd_addr,
    output logic [WAYS-1:0]    rd_dout,
    output logic               rd_valid,
    input  logic               wr_csb,
    input  logic [S_INDEX-1:0] wr_addr,
    input  logic [WAYS-1:0]    wr_mask,
    input  logic [WAYS-1:0]    wr_din,
    output logic               wr_ready,
    input  logic               inv_req,
    output logic               inv_busy,
    output logic               inv_done
);
    localparam int NUM_SETS = 2 ** S_INDEX;
    logic [WAYS-1:0] arr [NUM_SETS];
    logic clr_en;
    logic [S_INDEX-1:0] clr_addr;
    logic wr_en;
    logic [WAYS-1:0] wr_val;
    logic [WAYS-1:0] rd_val;
    valid_clear_seq #(.S_INDEX(S_INDEX)) u_seq (
        .clk0     (clk0),
        .rst0     (rst0),
        .inv_req  (inv_req),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .inv_busy (inv_busy),
        .inv_done (inv_done)
    );
    assign wr_ready = !inv_busy;
    assign wr_en = !wr_csb && wr_ready;
    assign wr_val = (arr[wr_addr] & ~wr_mask) | (wr_din & wr_mask);
`ifdef VALID_ARRAY_BYPASS_EN
    assign rd_val = (wr_en && wr_addr == rd_addr) ? wr_val : arr[rd_addr];
`else
    assign rd_val = arr[rd_addr];
`endif
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            for (int i = 0; i < NUM_SETS; i++) arr[i] <= '0;
        end else if (clr_en) begin
            arr[clr_addr] <= '0;
        end else if (wr_en) begin
            arr[wr_addr] <= wr_val;
        end
    end
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            rd_dout <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= !rd_csb;
            if (!rd_csb) rd_dout <= inv_busy ? '0 : rd_val;
        end
    end
endmodule

// File: tb/tb_valid_bank_array.sv
// tb_valid_bank_array: vector table, directed invalidate sequences and random traffic vs a set-level model.
module tb_valid_bank_array;
    localparam int SI = 4;
    localparam int W = 4;
    localparam int N = 16;
`ifdef VALID_ARRAY_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk0 = 1'b0, rst0 = 1'b0;
    logic rd_csb = 1'b1, wr_csb = 1'b1, inv_req = 1'b0;
    logic [SI-1:0] rd_addr = '0, wr_addr = '0;
    logic [W-1:0] wr_mask = '0, wr_din = '0;
    logic [W-1:0] rd_dout;
    logic rd_valid, wr_ready, inv_busy, inv_done;

    valid_bank_array dut (
        .clk0(clk0), .rst0(rst0),
        .rd_csb(rd_csb), .rd_addr(rd_addr), .rd_dout(rd_dout), .rd_valid(rd_valid),
        .wr_csb(wr_csb), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_din(wr_din),
        .wr_ready(wr_ready), .inv_req(inv_req), .inv_busy(inv_busy), .inv_done(inv_done)
    );

    always #5 clk0 = ~clk0;

    int errors = 0, checks = 0;
    logic [W-1:0] mem [N];
    int busy_left;
    logic m_rdv, m_done;
    logic [W-1:0] m_rdd;

    typedef struct {
        logic rcsb; logic [SI-1:0] raddr;
        logic wcsb; logic [SI-1:0] waddr; logic [W-1:0] wmask; logic [W-1:0] wdin;
        logic exp_rdv; logic [W-1:0] exp_rdd;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mem[i] = '0;
        busy_left = 0;
        m_rdv = 1'b0;
        m_done = 1'b0;
        m_rdd = '0;
    endtask

    // one clock: drive, predict from the set-level model, then compare after the edge
    task automatic step(input logic rcsb, input logic [SI-1:0] raddr, input logic wcsb,
                        input logic [SI-1:0] waddr, input logic [W-1:0] wmask,
                        input logic [W-1:0] wdin, input logic ireq, output bit wacc);
        bit idle;
        logic [W-1:0] merged;
        rd_csb = rcsb; rd_addr = raddr; wr_csb = wcsb; wr_addr = waddr;
        wr_mask = wmask; wr_din = wdin; inv_req = ireq;
        idle = busy_left == 0;
        wacc = !wcsb && idle;
        merged = (mem[waddr] & ~wmask) | (wdin & wmask);
        m_rdv = !rcsb;
        if (!rcsb) m_rdd = !idle ? '0 : (BYP && wacc && waddr == raddr) ? merged : mem[raddr];
        if (wacc) mem[waddr] = merged;
        m_done = 1'b0;
        if (!idle) begin
            mem[N - busy_left] = '0;
            busy_left--;
            m_done = busy_left == 0;
        end else if (ireq) begin
            busy_left = N;
        end
        @(posedge clk0);
        #1;
        chk("rd_valid", rd_valid, m_rdv);
        chk("rd_dout", rd_dout, m_rdd);
        chk("inv_busy", inv_busy, busy_left > 0);
        chk("wr_ready", wr_ready, busy_left == 0);
        chk("inv_done", inv_done, m_done);
    endtask

    task automatic idle_step(output bit wacc);
        step(1'b1, '0, 1'b1, '0, '0, '0, 1'b0, wacc);
    endtask

    initial begin
        bit wa;
        int busy_cnt, done_cnt, n;
        bit done_seen, late_ok;
        vecs[0] = '{1, 0, 0, 3, 4'b0101, 4'b1111, 0, 4'b0000};
        vecs[1] = '{0, 3, 1, 0, 4'b0000, 4'b0000, 1, 4'b0101};
        vecs[2] = '{1, 0, 0, 5, 4'b1111, 4'b1111, 0, 4'b0101};
        vecs[3] = '{1, 0, 0, 5, 4'b0010, 4'b0000, 0, 4'b0101};
        vecs[4] = '{0, 5, 1, 0, 4'b0000, 4'b0000, 1, 4'b1101};
        vecs[5] = '{0, 7, 0, 7, 4'b1000, 4'b1000, 1, BYP ? 4'b1000 : 4'b0000};
        vecs[6] = '{0, 7, 1, 0, 4'b0000, 4'b0000, 1, 4'b1000};
        model_reset();
        repeat (2) @(posedge clk0);
        #1;
        chk("reset rd_dout", rd_dout, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset inv_busy", inv_busy, 0);
        chk("reset inv_done", inv_done, 0);
        chk("reset wr_ready", wr_ready, 1);
        rst0 = 1'b1;

        for (int i = 0; i < 7; i++) begin
            step(vecs[i].rcsb, vecs[i].raddr, vecs[i].wcsb, vecs[i].waddr,
                 vecs[i].wmask, vecs[i].wdin, 1'b0, wa);
            chk($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].exp_rdv);
            chk($sformatf("vec%0d rd_dout", i), rd_dout, vecs[i].exp_rdd);
        end

        // fill every set, invalidate, and hold a write to set 2 across the sequence
        for (int s = 0; s < N; s++) step(1'b1, '0, 1'b0, SI'(s), 4'b1111, W'($urandom_range(1, 15)), 1'b0, wa);
        step(1'b1, '0, 1'b1, '0, '0, '0, 1'b1, wa);
        busy_cnt = int'(inv_busy);
        done_cnt = 0;
        done_seen = 1'b0;
        late_ok = 1'b0;
        for (n = 0; n < 40; n++) begin
            bit busy_before;
            busy_before = inv_busy;
            step(1'b0, SI'(n), 1'b0, 4'd2, 4'b1111, 4'b1010, 1'b0, wa);
            busy_cnt += int'(inv_busy);
            done_cnt += int'(inv_done);
            if (wa) begin
                late_ok = done_seen && !busy_before;
                break;
            end
            done_seen |= inv_done;
        end
        chk("inv busy cycles", busy_cnt, N);
        chk("inv done pulses", done_cnt, 1);
        chk("held write after done", late_ok, 1);
        chk("held write bound", n < 40, 1);
        idle_step(wa);
        for (int s = 0; s < N; s++) begin
            step(1'b0, SI'(s), 1'b1, '0, '0, '0, 1'b0, wa);
            chk($sformatf("post-inv set%0d", s), rd_dout, s == 2 ? 4'b1010 : 4'b0000);
        end

        // second inv_req mid-sequence must not extend it
        step(1'b1, '0, 1'b1, '0, '0, '0, 1'b1, wa);
        busy_cnt = int'(inv_busy);
        done_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, '0, 1'b1, '0, '0, '0, i == 5, wa);
            busy_cnt += int'(inv_busy);
            done_cnt += int'(inv_done);
        end
        chk("re-req busy cycles", busy_cnt, N);
        chk("re-req done pulses", done_cnt, 1);

        // asynchronous reset in the middle of a clear
        step(1'b1, '0, 1'b1, '0, '0, '0, 1'b1, wa);
        for (int i = 0; i < 7; i++) idle_step(wa);
        chk("busy before abort", inv_busy, 1);
        #3 rst0 = 1'b0;
        #1;
        chk("abort inv_busy", inv_busy, 0);
        chk("abort rd_valid", rd_valid, 0);
        chk("abort rd_dout", rd_dout, 0);
        chk("abort wr_ready", wr_ready, 1);
        model_reset();
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk0);
            done_cnt += int'(inv_done);
        end
        chk("abort no done", done_cnt, 0);
        @(posedge clk0);
        #1 rst0 = 1'b1;
        step(1'b1, '0, 1'b1, '0, '0, '0, 1'b1, wa);
        busy_cnt = int'(inv_busy);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            idle_step(wa);
            busy_cnt += int'(inv_busy);
            done_cnt += int'(inv_done);
        end
        chk("post-abort busy cycles", busy_cnt, N);
        chk("post-abort done pulses", done_cnt, 1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), SI'($urandom), 1'($urandom_range(0, 1)), SI'($urandom),
                 W'($urandom), W'($urandom), $urandom_range(0, 24) == 0, wa);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
